// File: rtl/sim_jtag_tap_pkg.sv
// Shared types and helpers for the simulation JTAG TAP endpoint.
//   tap_state_e : 16-state IEEE 1149.1 TAP controller encoding
//   IDCODE_OP   : opcode selecting the IDCODE register (reset instruction)
//   BYPASS_OP   : opcode selecting BYPASS (all ones)
//   tap_next()  : TAP next-state function for one rising TCK edge
package sim_jtag_tap_pkg;

    localparam int unsigned OPCODE_BITS = 5;

    localparam logic [OPCODE_BITS-1:0] IDCODE_OP = 5'h01;
    localparam logic [OPCODE_BITS-1:0] BYPASS_OP = 5'h1F;

    typedef enum logic [3:0] {
        TLR      = 4'h0,
        RTI      = 4'h1,
        SEL_DR   = 4'h2,
        CAP_DR   = 4'h3,
        SH_DR    = 4'h4,
        EX1_DR   = 4'h5,
        PAUSE_DR = 4'h6,
        EX2_DR   = 4'h7,
        UPD_DR   = 4'h8,
        SEL_IR   = 4'h9,
        CAP_IR   = 4'hA,
        SH_IR    = 4'hB,
        EX1_IR   = 4'hC,
        PAUSE_IR = 4'hD,
        EX2_IR   = 4'hE,
        UPD_IR   = 4'hF
    } tap_state_e;

    // TAP state transition taken on a rising TCK edge with the sampled TMS.
    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        nxt = TLR;
        case (state)
            TLR:      nxt = tms ? TLR    : RTI;
            RTI:      nxt = tms ? SEL_DR : RTI;
            SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
            SH_DR:    nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:   nxt = tms ? SEL_DR : RTI;
            SEL_IR:   nxt = tms ? TLR    : CAP_IR;
            CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
            SH_IR:    nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:   nxt = tms ? SEL_DR : RTI;
            default:  nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sim_jtag_tap_fsm.sv
// TAP controller state machine, advanced only on detected rising TCK edges.
//   clock     : system clock
//   test_rst  : synchronous reset (system reset or sampled TRSTn low)
//   tck_rise  : one-clock strobe for a rising TCK edge
//   tms       : TMS pin, sampled with the strobe
//   state     : current TAP state (registered)
module sim_jtag_tap_fsm
    import sim_jtag_tap_pkg::*;
(
    input  logic       clock,
    input  logic       test_rst,
    input  logic       tck_rise,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_next;

    // State register.
    always_ff @(posedge clock) begin
        state <= state_next;
    end

    // Next state; test reset wins over any edge in the same clock.
    always_comb begin
        state_next = state;
        if (test_rst) begin
            state_next = TLR;
        end else if (tck_rise) begin
            state_next = tap_next(state, tms);
        end
    end

endmodule

// File: rtl/sim_jtag_tap.sv
// JTAG TAP endpoint for the simulation JTAG driver, clocked by the system clock.
// TCK is oversampled and edge-detected; it never clocks any flop.
// Optional: define SIM_JTAG_TAP_TCK_FILTER_EN to require TCK stable for two
// clocks before its level is accepted (glitch filter, 3-clock pin latency).
//   clock, reset          : system clock, synchronous active-high reset
//   jtag_TCK/TMS/TDI      : JTAG pins from the driver
//   jtag_TRSTn            : active-low test reset, sampled on clock
//   jtag_TDO_data/driven  : TDO value and "driving" flag back to the driver
//   ir_value              : current (updated) instruction
//   dr_capture_data       : loaded into the user DR at Capture-DR
//   dr_update_valid/data  : one-clock pulse and shifted value at Update-DR
module sim_jtag_tap
    import sim_jtag_tap_pkg::*;
#(
    parameter int unsigned          IR_BITS    = 5,
    parameter int unsigned          DR_BITS    = 32,
    parameter logic [31:0]          IDCODE_VAL = 32'h0000_0001,
    parameter logic [IR_BITS-1:0]   USER_IR    = IR_BITS'(5'h10)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               jtag_TCK,
    input  logic               jtag_TMS,
    input  logic               jtag_TDI,
    input  logic               jtag_TRSTn,
    output logic               jtag_TDO_data,
    output logic               jtag_TDO_driven,
    output logic [IR_BITS-1:0] ir_value,
    input  logic [DR_BITS-1:0] dr_capture_data,
    output logic               dr_update_valid,
    output logic [DR_BITS-1:0] dr_update_data
);

    localparam int unsigned        IDCODE_BITS = 32;
    localparam logic [31:0]        IDCODE_EFF  = {IDCODE_VAL[31:1], 1'b1};
    localparam logic [IR_BITS-1:0] IDCODE_IR   = IR_BITS'(IDCODE_OP);
    localparam logic [IR_BITS-1:0] BYPASS_IR   = {IR_BITS{1'b1}};

    // A user opcode aliasing a built-in instruction would be unreachable.
    if (USER_IR == IDCODE_IR || USER_IR == BYPASS_IR) begin : g_bad_user_ir
        $error("sim_jtag_tap: USER_IR must differ from IDCODE and BYPASS opcodes");
    end

    logic test_rst_c;
    assign test_rst_c = reset | ~jtag_TRSTn;

    // TCK level seen by the edge detector.
    logic tck_q;
    logic tck_level_c;

`ifdef SIM_JTAG_TAP_TCK_FILTER_EN
    logic tck_s0;
    logic tck_s1;

    // Two-sample history of the pin; level changes only once both agree.
    always_ff @(posedge clock) begin
        if (test_rst_c) begin
            tck_s0 <= 1'b0;
            tck_s1 <= 1'b0;
        end else begin
            tck_s0 <= jtag_TCK;
            tck_s1 <= tck_s0;
        end
    end

    assign tck_level_c = (tck_s0 == tck_s1) ? tck_s0 : tck_q;
`else
    assign tck_level_c = jtag_TCK;
`endif

    always_ff @(posedge clock) begin
        if (test_rst_c) begin
            tck_q <= 1'b0;
        end else begin
            tck_q <= tck_level_c;
        end
    end

    logic tck_rise_c;
    logic tck_fall_c;
    assign tck_rise_c = tck_level_c & ~tck_q;
    assign tck_fall_c = ~tck_level_c & tck_q;

    tap_state_e state;

    sim_jtag_tap_fsm u_fsm (
        .clock    (clock),
        .test_rst (test_rst_c),
        .tck_rise (tck_rise_c),
        .tms      (jtag_TMS),
        .state    (state)
    );

    // Instruction decode; anything not IDCODE or USER falls back to BYPASS.
    logic sel_idcode_c;
    logic sel_user_c;
    assign sel_idcode_c = (ir_value == IDCODE_IR);
    assign sel_user_c   = (ir_value == USER_IR);

    logic [IR_BITS-1:0]     ir_shift;
    logic [IDCODE_BITS-1:0] idcode_sr;
    logic                   bypass_sr;
    logic [DR_BITS-1:0]     user_sr;

    // Capture/shift/update act on rising TCK using the state before the edge;
    // TDO is launched on falling TCK from the state after the rising edge.
    always_ff @(posedge clock) begin
        if (test_rst_c) begin
            ir_shift        <= '0;
            ir_value        <= IDCODE_IR;
            idcode_sr       <= '0;
            bypass_sr       <= 1'b0;
            user_sr         <= '0;
            jtag_TDO_data   <= 1'b0;
            jtag_TDO_driven <= 1'b0;
            dr_update_valid <= 1'b0;
            dr_update_data  <= '0;
        end else begin
            dr_update_valid <= 1'b0;
            if (tck_rise_c) begin
                case (state)
                    CAP_IR: ir_shift <= IR_BITS'(2'b01);
                    SH_IR:  ir_shift <= {jtag_TDI, ir_shift[IR_BITS-1:1]};
                    UPD_IR: ir_value <= ir_shift;
                    CAP_DR: begin
                        if (sel_idcode_c) begin
                            idcode_sr <= IDCODE_EFF;
                        end else if (sel_user_c) begin
                            user_sr <= dr_capture_data;
                        end else begin
                            bypass_sr <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (sel_idcode_c) begin
                            idcode_sr <= {jtag_TDI, idcode_sr[IDCODE_BITS-1:1]};
                        end else if (sel_user_c) begin
                            if (DR_BITS > 1) begin
                                user_sr <= {jtag_TDI, user_sr[DR_BITS-1:1]};
                            end else begin
                                user_sr <= DR_BITS'(jtag_TDI);
                            end
                        end else begin
                            bypass_sr <= jtag_TDI;
                        end
                    end
                    UPD_DR: begin
                        if (sel_user_c) begin
                            dr_update_data  <= user_sr;
                            dr_update_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (tck_fall_c) begin
                jtag_TDO_driven <= (state == SH_DR) || (state == SH_IR);
                if (state == SH_IR) begin
                    jtag_TDO_data <= ir_shift[0];
                end else if (state == SH_DR) begin
                    if (sel_idcode_c) begin
                        jtag_TDO_data <= idcode_sr[0];
                    end else if (sel_user_c) begin
                        jtag_TDO_data <= user_sr[0];
                    end else begin
                        jtag_TDO_data <= bypass_sr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sim_jtag_tap.sv
// Self-checking bench for sim_jtag_tap: drives TCK as a slow level on clock
// negedges, queues expected TDO bits as they are shifted and compares them
// against the pin sampled just before each rising TCK.
module tb_sim_jtag_tap;
    import sim_jtag_tap_pkg::*;

    localparam int unsigned IR_BITS = 5;
    localparam int unsigned DR_BITS = 32;
    localparam logic [IR_BITS-1:0] USER_OP = 5'h10;

    logic               clock = 1'b0;
    logic               reset;
    logic               jtag_TCK;
    logic               jtag_TMS;
    logic               jtag_TDI;
    logic               jtag_TRSTn;
    logic               jtag_TDO_data;
    logic               jtag_TDO_driven;
    logic [IR_BITS-1:0] ir_value;
    logic [DR_BITS-1:0] dr_capture_data;
    logic               dr_update_valid;
    logic [DR_BITS-1:0] dr_update_data;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic exp_q[$];

    sim_jtag_tap dut (
        .clock           (clock),
        .reset           (reset),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .ir_value        (ir_value),
        .dr_capture_data (dr_capture_data),
        .dr_update_valid (dr_update_valid),
        .dr_update_data  (dr_update_data)
    );

    always #5 clock = ~clock;

    // Count clocks with the update strobe high (pulse width and count check).
    always @(posedge clock) begin
        if (dr_update_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full TCK period: 4 clocks high, 4 clocks low.
    task automatic tck(input logic tms, input logic tdi);
        @(negedge clock);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        jtag_TCK = 1'b1;
        repeat (4) @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Walk to Shift-DR from TLR or RTI, checking TDO is idle on the way.
    task automatic enter_shift_dr();
        tck(1'b0, 1'b0);
        tck(1'b1, 1'b0);
        check("seldr_drv", 32'(jtag_TDO_driven), 32'd0);
        tck(1'b0, 1'b0);
        check("capdr_drv", 32'(jtag_TDO_driven), 32'd0);
        tck(1'b0, 1'b0);
    endtask

    // Shift n DR bits then exit through Update-DR to RTI.
    task automatic shift_dr(input int n, input logic [31:0] tdi_v, input logic [31:0] exp_v);
        enter_shift_dr();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_v[i]);
        for (int i = 0; i < n; i++) begin
            check($sformatf("dr_drv%0d", i), 32'(jtag_TDO_driven), 32'd1);
            check($sformatf("dr_tdo%0d", i), 32'(jtag_TDO_data), 32'(exp_q.pop_front()));
            tck(i == n - 1, tdi_v[i]);
        end
        check("ex1dr_drv", 32'(jtag_TDO_driven), 32'd0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    // Load an instruction, checking the captured 2'b01 pattern on TDO.
    task automatic shift_ir(input logic [IR_BITS-1:0] op);
        tck(1'b0, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        for (int i = 0; i < int'(IR_BITS); i++) exp_q.push_back(i == 0);
        for (int i = 0; i < int'(IR_BITS); i++) begin
            check($sformatf("ir_drv%0d", i), 32'(jtag_TDO_driven), 32'd1);
            check($sformatf("ir_tdo%0d", i), 32'(jtag_TDO_data), 32'(exp_q.pop_front()));
            tck(i == int'(IR_BITS) - 1, op[i]);
        end
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        check("ir_value", 32'(ir_value), 32'(op));
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        jtag_TCK = 1'b0;
        jtag_TMS = 1'b1;
        jtag_TDI = 1'b0;
        jtag_TRSTn = 1'b1;
        dr_capture_data = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_state", 32'(dut.state), 32'(TLR));
        check("rst_ir", 32'(ir_value), 32'h01);
        check("rst_tdo", 32'(jtag_TDO_data), 32'd0);
        check("rst_drv", 32'(jtag_TDO_driven), 32'd0);
        check("rst_valid", 32'(dr_update_valid), 32'd0);
        check("rst_data", dr_update_data, 32'd0);

        for (int i = 0; i < 5; i++) begin
            tck(1'b1, 1'b0);
            check($sformatf("tlr_drv%0d", i), 32'(jtag_TDO_driven), 32'd0);
        end
        check("tlr_state", 32'(dut.state), 32'(TLR));
        check("tlr_ir", 32'(ir_value), 32'h01);

        // IDCODE read, no update pulse.
        p0 = pulse_cnt;
        shift_dr(32, 32'h0, 32'h0000_0001);
        check("idcode_nopulse", 32'(pulse_cnt - p0), 32'd0);

        // BYPASS: one-bit delay from TDI to TDO.
        shift_ir(5'h1F);
        shift_dr(3, 32'b101, 32'b010);

        // User DR capture, shift and update.
        shift_ir(USER_OP);
        dr_capture_data = 32'hDEAD_BEEF;
        p0 = pulse_cnt;
        shift_dr(32, 32'h1234_5678, 32'hDEAD_BEEF);
        check("user_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("user_data", dr_update_data, 32'h1234_5678);
        check("user_state", 32'(dut.state), 32'(RTI));

        // TRSTn mid Shift-DR discards the shift.
        p0 = pulse_cnt;
        enter_shift_dr();
        for (int i = 0; i < 8; i++) tck(1'b0, 1'b1);
        check("pre_trst_state", 32'(dut.state), 32'(SH_DR));
        @(negedge clock);
        jtag_TRSTn = 1'b0;
        @(negedge clock);
        jtag_TRSTn = 1'b1;
        check("trst_state", 32'(dut.state), 32'(TLR));
        check("trst_ir", 32'(ir_value), 32'h01);
        check("trst_drv", 32'(jtag_TDO_driven), 32'd0);
        check("trst_data", dr_update_data, 32'd0);
        tck(1'b1, 1'b0);
        tck(1'b1, 1'b0);
        check("trst_nopulse", 32'(pulse_cnt - p0), 32'd0);
        check("trst_tlr", 32'(dut.state), 32'(TLR));

`ifdef SIM_JTAG_TAP_TCK_FILTER_EN
        // Single-clock TCK glitch must not advance the FSM.
        tck(1'b0, 1'b0);
        check("pre_glitch", 32'(dut.state), 32'(RTI));
        @(negedge clock);
        jtag_TMS = 1'b1;
        jtag_TCK = 1'b1;
        @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (6) @(negedge clock);
        check("glitch_state", 32'(dut.state), 32'(RTI));
`endif

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_left: got=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_jtag_tap.md
Name: sim_jtag_tap

Overview:
- JTAG TAP endpoint that consumes the TCK/TMS/TDI/TRSTn pins produced by the simulation JTAG driver and returns TDO data plus a driven flag to it.
- Runs entirely in the system clock domain: TCK is oversampled and edge-detected, not used as a clock.
- Implements the 16-state IEEE 1149.1 TAP FSM, an instruction register, IDCODE, BYPASS and one user data register exposed to the debug module.

Parameters:
- IR_BITS, 5, instruction register width (>=2).
- DR_BITS, 32, user data register width (>=1).
- IDCODE_VAL, 32'h0000_0001, IDCODE value; bit0 forced to 1.
- USER_IR, 5'h10, opcode selecting the user DR.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- jtag_TCK  in  1  TCK level, changes only on clock negedge.
- jtag_TMS  in  1  TMS.
- jtag_TDI  in  1  TDI.
- jtag_TRSTn  in  1  active-low test reset, sampled.
- jtag_TDO_data  out  1  TDO value.
- jtag_TDO_driven  out  1  high only while shifting.
- ir_value  out  IR_BITS  current (updated) instruction.
- dr_capture_data  in  DR_BITS  loaded into the user DR at Capture-DR.
- dr_update_valid  out  1  one-clock pulse on Update-DR with IR==USER_IR.
- dr_update_data  out  DR_BITS  shifted user DR; valid with the pulse, held otherwise.

Behaviour:
- Reset (reset=1 or sampled jtag_TRSTn=0) sets the following, applied on the next clock edge:
  - state=TEST_LOGIC_RESET, ir_value=IDCODE opcode (5'h01), tck_q=0.
  - TDO_data=0, TDO_driven=0, dr_update_valid=0, dr_update_data=0.
- Edge detect:
  - tck_q registers jtag_TCK each posedge.
  - rise = jtag_TCK & ~tck_q; fall = ~jtag_TCK & tck_q.
  - An edge is acted on in the same clock it is detected; latency is 1 clock from the pin change.
- On rise:
  - Sample TMS/TDI.
  - Advance the FSM per 1149.1: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents.
  - TLR with TMS=1 stays in TLR; five TMS=1 rises from any state reach TLR.
- Register actions, evaluated in the state before the rise:
  - CapIR: ir_shift <= {zeros, 2'b01}.
  - ShIR: ir_shift <= {TDI, ir_shift[IR_BITS-1:1]}.
  - UpdIR: ir_value <= ir_shift.
  - CapDR loads by selected instruction:
    - IDCODE: idcode shift register <= IDCODE_VAL.
    - BYPASS or any undefined opcode: bypass <= 0.
    - USER_IR: user shift register <= dr_capture_data.
  - ShDR: the selected register shifts LSB-first, TDI entering at the MSB.
  - UpdDR with USER_IR: dr_update_data <= user shift register; dr_update_valid=1 for exactly one clock.
- On fall:
  - TDO_data <= LSB of the selected shift register (IR when in ShIR).
  - TDO_driven <= (state==ShDR || state==ShIR).
  - Outside shift states, TDO_driven=0 and TDO_data holds its value.
- Simultaneous cases:
  - TRSTn low overrides any edge in that clock.
  - Reset mid-shift discards the partial shift; no update pulse is generated.
- Instruction decode: all-ones opcode means BYPASS; a USER_IR value equal to IDCODE or BYPASS is illegal (elaboration assert).

Optional Feature:
- Macro: SIM_JTAG_TAP_TCK_FILTER_EN.
- Defined:
  - A 2-stage filter requires jtag_TCK stable for 2 consecutive clocks before the filtered level changes.
  - Edges are detected on the filtered level.
  - Pin-to-action latency becomes 3 clocks.
  - Single-clock TCK glitches are ignored.
- Undefined: direct 1-clock edge detect as above.

Decomposition:
- Package sim_jtag_tap_pkg contains:
  - tap_state_e enum (16 states, 4 bits).
  - Opcode constants IDCODE_OP and BYPASS_OP.
  - Function tap_next(state, tms).
- Sub-module sim_jtag_tap_fsm: state register plus next-state logic, with edge strobe input and TRSTn/reset input. Data registers stay in the top.

Test Plan:
- Reset, then 5 TCK cycles with TMS=1 → state TLR, ir_value=5'h01, TDO_driven=0 throughout.
- From TLR, TMS sequence 0,1,0,0 and shift 32 bits → TDO bits LSB-first form 32'h0000_0001; TDO_driven=1 only during ShDR.
- Load IR=5'h1F, then shift DR with TDI pattern 1,0,1 → TDO returns 0,1,0 (1-bit bypass delay).
- Load IR=USER_IR, dr_capture_data=32'hDEAD_BEEF, shift in 32'h1234_5678 → TDO yields DEADBEEF LSB-first; at UpdDR dr_update_valid pulses one clock with dr_update_data=32'h1234_5678.
- Shift IR → first two TDO bits are 1,0 (capture 2'b01).
- Assert TRSTn=0 mid-ShDR for 1 clock → next state TLR, ir_value=5'h01, no dr_update_valid pulse; with SIM_JTAG_TAP_TCK_FILTER_EN, also inject a 1-clock TCK glitch → no state change.
